kbd_source_arbiter: RTL and testbench

Merges the two Apple 1 keyboard sources, the PS/2 scan decoder and the UART receiver, into the single keyboard register read by the 6821 PIA. Each source delivers non-stallable one-cycle byte pulses. The block captures them in per-source holding registers, schedules them round-robin into a small FIFO, and presents one character at a time to the PIA with a strobe/acknowledge handshake. It sits between the input decoders and the PIA inside the `apple1` core, and replaces the static PS/2-or-UART select.

---
 rtl/kbd_source_arbiter.sv | 125 ++++++++++++
 tb/tb_kbd_source_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_source_arbiter.sv
// Merges PS/2 and UART byte pulses into one PIA keyboard register; pulse to strobe in 2 cycles, one char per ack.
// Sources cannot stall: a byte arriving while its holding register is still full is dropped with an overrun pulse. Optional: KBD_ARB_UPCASE_EN.
module kbd_source_arbiter #(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk25,
  input  logic          rst,
  input  logic          ps2_en,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_valid,
  input  logic          uart_en,
  input  logic [7:0]    uart_data,
  input  logic          uart_valid,
  output logic [6:0]    key_data,
  output logic          key_strobe,
  input  logic          key_ack,
  output logic          overrun,
  output logic [CW-1:0] fifo_count
);

  typedef enum logic {ST_EMPTY, ST_PRESENT} state_t;

  state_t        state;
  logic          ps2_full, uart_full;
  logic [6:0]    ps2_hold, uart_hold;
  logic          prio;  // 0 = PS/2 wins a tie, 1 = UART
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic       ps2_cap, uart_cap, fifo_full, pop, wr_ok;
  logic       gnt_ps2, gnt_uart, wr;
  logic [6:0] wr_dat, sel_dat;

  function automatic logic [6:0] map_char(input logic [6:0] d);
`ifdef KBD_ARB_UPCASE_EN
    if (d >= 7'h61 && d <= 7'h7A) return d - 7'h20;
`endif
    return d;
  endfunction

  // LF is swallowed here so it never occupies a holding slot or causes overrun
  assign ps2_cap   = ps2_valid & ps2_en & (ps2_data[6:0] != 7'h0A);
  assign uart_cap  = uart_valid & uart_en & (uart_data[6:0] != 7'h0A);

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = (state == ST_EMPTY) && (fifo_count != '0);
  assign wr_ok     = !fifo_full || pop;
  assign gnt_ps2   = wr_ok & ps2_full & (!uart_full | !prio);
  assign gnt_uart  = wr_ok & uart_full & (!ps2_full | prio);
  assign wr        = gnt_ps2 | gnt_uart;
  assign sel_dat   = gnt_ps2 ? ps2_hold : uart_hold;
  assign wr_dat    = map_char(sel_dat);

  always_ff @(posedge clk25) begin
    if (wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state      <= ST_EMPTY;
      key_strobe <= 1'b0;
      key_data   <= '0;
      ps2_full   <= 1'b0;
      uart_full  <= 1'b0;
      ps2_hold   <= '0;
      uart_hold  <= '0;
      prio       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      // a slot drained this cycle can take a new byte in the same cycle
      if (ps2_cap && (!ps2_full || gnt_ps2)) begin
        ps2_full <= 1'b1;
        ps2_hold <= ps2_data[6:0];
      end else if (gnt_ps2) begin
        ps2_full <= 1'b0;
      end

      if (uart_cap && (!uart_full || gnt_uart)) begin
        uart_full <= 1'b1;
        uart_hold <= uart_data[6:0];
      end else if (gnt_uart) begin
        uart_full <= 1'b0;
      end

      overrun <= (ps2_cap & ps2_full & !gnt_ps2) | (uart_cap & uart_full & !gnt_uart);

      if (gnt_ps2)       prio <= 1'b1;
      else if (gnt_uart) prio <= 1'b0;

      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        ST_EMPTY: begin
          if (pop) begin
            key_data   <= mem[rd_ptr];
            key_strobe <= 1'b1;
            state      <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (key_ack) begin
            key_strobe <= 1'b0;
            state      <= ST_EMPTY;
          end
        end
        default: begin
          key_strobe <= 1'b0;
          state      <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Random and directed traffic against a queue-based model of the keyboard merger; a monitor scoreboards presented characters.
module tb_kbd_source_arbiter;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk25, rst;
  logic          ps2_en, ps2_valid, uart_en, uart_valid, key_ack;
  logic [7:0]    ps2_data, uart_data;
  logic [6:0]    key_data;
  logic          key_strobe, overrun;
  logic [CW-1:0] fifo_count;

  kbd_source_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk25(clk25), .rst(rst),
    .ps2_en(ps2_en), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .uart_en(uart_en), .uart_data(uart_data), .uart_valid(uart_valid),
    .key_data(key_data), .key_strobe(key_strobe), .key_ack(key_ack),
    .overrun(overrun), .fifo_count(fifo_count)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  int n_chk = 0, n_fail = 0, ovr_seen = 0;

  // Reference model: per-source slot (0/1 entry), character queue, output register
  logic [6:0] ps2_h[$], uart_h[$], fq[$], sb[$], log_q[$];
  bit         m_pres, m_prio, m_ovr;
  logic [6:0] m_out;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] up(logic [6:0] c);
`ifdef KBD_ARB_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
    return c;
  endfunction

  task automatic model(bit pv, logic [7:0] pd, bit uv, logic [7:0] ud, bit ack, bit r);
    bit pop, can_w, drop;
    int g;
    if (r) begin
      ps2_h.delete(); uart_h.delete(); fq.delete();
      m_pres = 0; m_prio = 0; m_ovr = 0; m_out = 0;
      return;
    end
    pop   = !m_pres && fq.size() > 0;
    can_w = fq.size() < D || pop;
    g = 0;
    if (can_w) begin
      if (ps2_h.size() > 0 && uart_h.size() > 0) g = m_prio ? 2 : 1;
      else if (ps2_h.size() > 0)                 g = 1;
      else if (uart_h.size() > 0)                g = 2;
    end
    if (pop) begin
      m_out  = fq.pop_front();
      m_pres = 1;
      sb.push_back(m_out);
    end else if (m_pres && ack) begin
      m_pres = 0;
    end
    if (g == 1) begin fq.push_back(up(ps2_h.pop_front()));  m_prio = 1; end
    if (g == 2) begin fq.push_back(up(uart_h.pop_front())); m_prio = 0; end
    drop = 0;
    if (pv && ps2_en && pd[6:0] != 7'h0A) begin
      if (ps2_h.size() > 0) drop = 1; else ps2_h.push_back(pd[6:0]);
    end
    if (uv && uart_en && ud[6:0] != 7'h0A) begin
      if (uart_h.size() > 0) drop = 1; else uart_h.push_back(ud[6:0]);
    end
    m_ovr = drop;
  endtask

  task automatic step(bit pv, logic [7:0] pd, bit uv, logic [7:0] ud, bit ack, bit r);
    @(negedge clk25);
    ps2_valid = pv; ps2_data = pd; uart_valid = uv; uart_data = ud;
    key_ack = ack; rst = r;
    @(posedge clk25);
    model(pv, pd, uv, ud, ack, r);
    #1;
    chk("key_strobe", key_strobe, m_pres);
    chk("fifo_count", fifo_count, fq.size());
    chk("overrun", overrun, m_ovr);
    if (overrun) ovr_seen++;
  endtask

  task automatic idle(int n, bit ack);
    repeat (n) step(0, 8'h00, 0, 8'h00, ack, 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((m_pres || fq.size() > 0 || ps2_h.size() > 0 || uart_h.size() > 0) && k < 200) begin
      step(0, 8'h00, 0, 8'h00, 1, 0);
      k++;
    end
    chk("drain_bound", k < 200, 1);
    idle(2, 0);
  endtask

  // Monitor: each strobe rise must present the next character the model popped
  initial begin : monitor
    bit prev = 0;
    logic [6:0] exp;
    forever begin
      @(posedge clk25);
      #2;
      if (key_strobe === 1'b1 && !prev) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_strobe", 1, 0);
        end else begin
          exp = sb.pop_front();
          chk("key_data", key_data, exp);
        end
        log_q.push_back(key_data);
      end
      prev = (key_strobe === 1'b1);
    end
  end

  initial begin : stim
    logic [6:0] burst_exp[6];
    logic [6:0] lf_exp[2];
    rst = 1; ps2_en = 1; uart_en = 1; ps2_valid = 0; uart_valid = 0;
    ps2_data = 0; uart_data = 0; key_ack = 0;
    step(0, 8'h00, 0, 8'h00, 0, 1);
    step(1, 8'h41, 1, 8'h42, 1, 1);
    chk("reset_key_data", key_data, 0);

    // single character latency and ack
    log_q.delete();
    step(1, 8'h41, 0, 8'h00, 0, 0);
    idle(3, 0);
    chk("single_data", key_data, 7'h41);
    step(0, 8'h00, 0, 8'h00, 1, 0);
    idle(2, 0);
    chk("single_count", fifo_count, 0);

    // simultaneous pairs exercise the priority pointer
    step(1, 8'h31, 1, 8'h32, 0, 0);
    drain();
    step(1, 8'h31, 1, 8'h32, 0, 0);
    drain();
    step(0, 8'h00, 1, 8'h44, 0, 0);
    step(1, 8'h31, 1, 8'h32, 0, 0);
    drain();

    // burst with no acks overflows the UART slot twice
    log_q.delete(); ovr_seen = 0;
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 8'(8'h30 + i), 0, 0);
    idle(3, 0);
    chk("burst_overruns", ovr_seen, 2);
    chk("burst_count", fifo_count, 4);
    drain();
    for (int i = 0; i < 6; i++) burst_exp[i] = 7'(7'h30 + i);
    chk("burst_len", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) chk("burst_order", log_q[i], burst_exp[i]);

    // LF filtering and optional upcase
    log_q.delete(); ovr_seen = 0;
    step(0, 8'h00, 1, 8'h0D, 0, 0);
    step(0, 8'h00, 1, 8'h0A, 0, 0);
    step(0, 8'h00, 1, 8'h61, 0, 0);
    drain();
    lf_exp[0] = 7'h0D;
`ifdef KBD_ARB_UPCASE_EN
    lf_exp[1] = 7'h41;
`else
    lf_exp[1] = 7'h61;
`endif
    chk("lf_len", log_q.size(), 2);
    for (int i = 0; i < 2 && i < log_q.size(); i++) chk("lf_seq", log_q[i], lf_exp[i]);
    chk("lf_no_overrun", ovr_seen, 0);

    // disabled UART source
    log_q.delete();
    uart_en = 0;
    step(1, 8'h42, 1, 8'h55, 0, 0);
    drain();
    uart_en = 1;
    chk("dis_len", log_q.size(), 1);
    if (log_q.size() > 0) chk("dis_data", log_q[0], 7'h42);

    // reset with characters queued and presented
    step(1, 8'h61, 0, 8'h00, 0, 0);
    step(1, 8'h62, 0, 8'h00, 0, 0);
    step(1, 8'h63, 0, 8'h00, 0, 0);
    idle(2, 0);
    chk("pre_reset_strobe", key_strobe, 1);
    step(1, 8'h64, 1, 8'h65, 1, 1);
    chk("rst_key_data", key_data, 0);
    chk("rst_strobe", key_strobe, 0);
    chk("rst_count", fifo_count, 0);
    log_q.delete();
    step(1, 8'h5A, 0, 8'h00, 0, 0);
    drain();
    chk("post_rst_len", log_q.size(), 1);
    if (log_q.size() > 0) chk("post_rst_data", log_q[0], 7'h5A);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] pd, ud;
      pd = 8'($urandom);
      ud = 8'($urandom);
      if ($urandom_range(7) == 0) pd = {pd[7], 7'h0A};
      if ($urandom_range(7) == 0) ud = {ud[7], 7'h0A};
      if ($urandom_range(31) == 0) ps2_en = ~ps2_en;
      if ($urandom_range(31) == 0) uart_en = ~uart_en;
      step($urandom_range(3) == 0, pd, $urandom_range(2) == 0, ud,
           $urandom_range(2) == 0, $urandom_range(199) == 0);
    end
    ps2_en = 1; uart_en = 1;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
